rf_ram_store: RTL

//  Block-store sequencer: copies a run of Register File words into data RAM.

---
 rtl/rf_ram_store.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/rf_ram_store.sv
// Block-store sequencer: copies a run of register-file words into data RAM,
// with an optional two-stage read-back compare that records the first mismatch.
module rf_ram_store #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int REG_AW = 4
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic [REG_AW-1:0] Src_Reg,
  input  logic [ADDR_W-1:0] Dst_Addr,
  input  logic [REG_AW:0]   Count,
  input  logic              Verify,
  output logic [REG_AW-1:0] RF_Rd_Addr,
  input  logic [DATA_W-1:0] RF_Rd_Data,
  output logic [ADDR_W-1:0] D_Addr,
  output logic              D_W_En,
  output logic [DATA_W-1:0] W_Data,
  input  logic [DATA_W-1:0] R_Data,
  output logic              Busy,
  output logic              Done,
  output logic              Mismatch,
  output logic [ADDR_W-1:0] Err_Addr
);

  localparam int CNT_W = REG_AW + 1;
  localparam logic [CNT_W-1:0] MAX_CNT = {1'b1, {REG_AW{1'b0}}};

  typedef enum logic [1:0] {IDLE, WRITE, VERIFY, DONE} state_t;

  state_t            state, state_nxt;
  logic [REG_AW-1:0] src_q;
  logic [ADDR_W-1:0] dst_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  idx_q;
  logic              verify_q;

  logic [DATA_W-1:0] exp_p1;
  logic [ADDR_W-1:0] tag_p1;
  logic              vld_p1;

  logic              accept;
  logic              last_wr;
  logic              verify_end;
  logic              issue;
  logic [REG_AW-1:0] rf_addr;
  logic [ADDR_W-1:0] ram_addr;

  function automatic logic [CNT_W-1:0] sat_count(input logic [CNT_W-1:0] c);
    return (c > MAX_CNT) ? MAX_CNT : c;
  endfunction

  assign accept     = (state == IDLE) && Start;
  assign last_wr    = (idx_q == (cnt_q - CNT_W'(1)));
  assign verify_end = (idx_q == cnt_q);
  assign issue      = (state == VERIFY) && !verify_end;
  assign rf_addr    = src_q + idx_q[REG_AW-1:0];
  assign ram_addr   = dst_q + ADDR_W'(idx_q);
  assign W_Data     = RF_Rd_Data;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Outputs decode from registered state/counters only, so Start never reaches D_W_En.
  always_comb begin
    state_nxt  = state;
    RF_Rd_Addr = '0;
    D_Addr     = '0;
    D_W_En     = 1'b0;
    Busy       = 1'b0;
    Done       = 1'b0;
    case (state)
      IDLE: begin
        if (Start) state_nxt = (sat_count(Count) != '0) ? WRITE : DONE;
      end
      WRITE: begin
        RF_Rd_Addr = rf_addr;
        D_Addr     = ram_addr;
        D_W_En     = 1'b1;
        Busy       = 1'b1;
        if (last_wr) state_nxt = verify_q ? VERIFY : DONE;
      end
      VERIFY: begin
        Busy = 1'b1;
        if (issue) begin
          RF_Rd_Addr = rf_addr;
          D_Addr     = ram_addr;
        end
        if (verify_end) state_nxt = DONE;
      end
      DONE: begin
        Done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      idx_q    <= '0;
      cnt_q    <= '0;
      verify_q <= 1'b0;
      vld_p1   <= 1'b0;
      Mismatch <= 1'b0;
      Err_Addr <= '0;
    end else begin
      vld_p1 <= issue;
      if (accept) begin
        cnt_q    <= sat_count(Count);
        verify_q <= Verify;
        Mismatch <= 1'b0;
        Err_Addr <= '0;
      end else if (vld_p1 && (R_Data != exp_p1) && !Mismatch) begin
        Mismatch <= 1'b1;
        Err_Addr <= tag_p1;
      end
      case (state)
        WRITE:   idx_q <= last_wr ? '0 : idx_q + CNT_W'(1);
        VERIFY:  idx_q <= idx_q + CNT_W'(1);
        default: idx_q <= '0;
      endcase
    end
  end

  // Stage p0 -> p1: capture expected word and its RAM address while the read is in flight.
  always_ff @(posedge Clock) begin
    if (accept) begin
      src_q <= Src_Reg;
      dst_q <= Dst_Addr;
    end
    if (issue) begin
      exp_p1 <= RF_Rd_Data;
      tag_p1 <= ram_addr;
    end
  end

endmodule
